// File: rtl/temp_digital_mc_pkg.sv
// Shared types and default sizing for the multi-channel VCO temperature counter.
package temp_digital_mc_pkg;

  localparam int NCH_DEF   = 4;
  localparam int CNT_W_DEF = 16;
  localparam int WIN_W_DEF = 16;
  localparam int SEL_W     = 3;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COUNT,
    LATCH
  } state_t;

endpackage

// File: rtl/tdm_edge_counter.sv
// One VCO channel: 2-flop synchroniser, rising-edge detect, saturating edge counter.
module tdm_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             vco,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - CNT_W'(1);

  logic sync_q1, sync_q2, prev_q;
  logic rise;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q1 <= vco;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
    end
  end

  assign rise = sync_q2 & ~prev_q;

  // The flag marks a channel pinned at full scale; the count never wraps.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (enable && rise) begin
      if (count != CNT_MAX) count <= count + CNT_W'(1);
      if (count >= CNT_NEAR) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/temp_digital_mc.sv
// Multi-channel VCO edge counter: counts each channel over a programmable window,
// latches results for parallel readback and a serial shift-out port.
module temp_digital_mc
  import temp_digital_mc_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic [NCH-1:0]   vco_in,
  input  logic             start,
  input  logic             cont_mode,
  input  logic [WIN_W-1:0] win_len,
  output logic             busy,
  output logic             done,
  output logic [NCH-1:0]   sat,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [CNT_W-1:0] rd_data,
  input  logic             shift_en,
  output logic             sr_out,
  output logic             sr_last
);

  localparam int SR_W = NCH * CNT_W;
  localparam int SL_W = $clog2(SR_W + 1);

  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_len_q, win_cnt_q;
  logic             window_end;

  logic [CNT_W-1:0] cnt      [NCH];
  logic [NCH-1:0]   cnt_sat;
  logic [CNT_W-1:0] result_q [NCH];
  logic [NCH-1:0]   sat_q;

  logic [SR_W-1:0]  sr_q, sr_load;
  logic [SL_W-1:0]  sr_left_q;

  assign window_end = (win_cnt_q == win_len_q - WIN_W'(1));

  // NOTE: every output of a combinational block is defaulted first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ARM;
      ARM:     state_d = COUNT;
      COUNT:   if (window_end) state_d = LATCH;
      LATCH:   state_d = cont_mode ? ARM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // win_len is captured in ARM so a mid-window change cannot stretch the count.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= IDLE;
      win_len_q <= '0;
      win_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ARM) begin
        win_cnt_q <= '0;
        win_len_q <= (win_len == '0) ? WIN_W'(1) : win_len;
      end else if (state_q == COUNT) begin
        win_cnt_q <= win_cnt_q + WIN_W'(1);
      end
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    tdm_edge_counter #(.CNT_W(CNT_W)) u_cnt (
      .wb_clk_i (wb_clk_i),
      .wb_rst_n (wb_rst_n),
      .vco      (vco_in[ch]),
      .clear    (state_q == ARM),
      .enable   (state_q == COUNT),
      .count    (cnt[ch]),
      .sat      (cnt_sat[ch])
    );
  end

  // NOTE: the result array is small and architecturally visible, so it is
  // reset like any other register rather than left as uninitialised storage.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int i = 0; i < NCH; i++) result_q[i] <= '0;
      sat_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state_q == LATCH);
      if (state_q == LATCH) begin
        for (int i = 0; i < NCH; i++) result_q[i] <= cnt[i];
        sat_q <= cnt_sat;
      end
    end
  end

  // Channel 0 occupies the top of the shift register so it leaves first.
  always_comb begin
    sr_load = '0;
    for (int i = 0; i < NCH; i++) sr_load[SR_W-1-i*CNT_W -: CNT_W] = cnt[i];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sr_q      <= '0;
      sr_left_q <= '0;
    end else if (state_q == LATCH) begin
      sr_q      <= sr_load;
      sr_left_q <= SL_W'(SR_W);
    end else if (shift_en) begin
      sr_q <= sr_q << 1;
      if (sr_left_q != '0) sr_left_q <= sr_left_q - SL_W'(1);
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_sel == SEL_W'(i)) rd_data = result_q[i];
    end
  end

  assign busy    = (state_q != IDLE);
  assign sat     = sat_q;
  assign sr_out  = sr_q[SR_W-1];
  assign sr_last = (sr_left_q == SL_W'(1));

endmodule
